// File: rtl/fir_tap_pipeline.sv
`default_nettype none
// fir_tap_pipeline: 4-tap signed FIR over a shift buffer's parallel taps, 3 register stages
// with fill-count qualification; rev 1.0
module fir_tap_pipeline #(
  parameter  int word_size = 8,
  parameter  int coef_size = 8,
  localparam int acc_size  = word_size + coef_size + 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [word_size-1:0] cell_3,
  input  logic signed [word_size-1:0] cell_2,
  input  logic signed [word_size-1:0] cell_1,
  input  logic signed [word_size-1:0] cell_0,
  input  logic                        in_valid,
  input  logic                        flush,
  input  logic                        coef_load,
  input  logic [1:0]                  coef_sel,
  input  logic signed [coef_size-1:0] coef_in,
  output logic signed [acc_size-1:0]  fir_out,
  output logic                        out_valid,
  output logic                        filled
);

  localparam int PW = word_size + coef_size;

  logic signed [word_size-1:0] tap_q  [4];
  logic signed [coef_size-1:0] coef_q [4];
  logic signed [PW-1:0]        prod_q [4];
  logic [2:0]                  cnt_q, cnt_d;
  logic                        v1_q, q1_q, v2_q;
  logic signed [acc_size-1:0]  fir_out_q, sum_d;
  logic                        out_valid_q;

  always_comb begin
    cnt_d = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
    sum_d = '0;
    for (int k = 0; k < 4; k++) begin
      sum_d = sum_d + {{2{prod_q[k][PW-1]}}, prod_q[k]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
        prod_q[k] <= '0;
      end
      cnt_q       <= 3'd0;
      v1_q        <= 1'b0;
      q1_q        <= 1'b0;
      v2_q        <= 1'b0;
      fir_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (coef_load) begin
        coef_q[coef_sel] <= coef_in;
      end

      // flush overrides a coincident sample: it is neither captured nor counted
      if (flush) begin
        cnt_q <= 3'd0;
        v1_q  <= 1'b0;
      end else if (in_valid) begin
        tap_q[0] <= cell_0;
        tap_q[1] <= cell_1;
        tap_q[2] <= cell_2;
        tap_q[3] <= cell_3;
        v1_q     <= 1'b1;
        q1_q     <= (cnt_q >= 3'd3);
        cnt_q    <= cnt_d;
      end else begin
        v1_q <= 1'b0;
      end

      // products use coefficient registers as they stand at this edge
      if (v1_q) begin
        for (int k = 0; k < 4; k++) begin
          prod_q[k] <= tap_q[k] * coef_q[k];
        end
      end
      v2_q <= flush ? 1'b0 : (v1_q & q1_q);

      out_valid_q <= flush ? 1'b0 : v2_q;
      if (v2_q && !flush) begin
        fir_out_q <= sum_d;
      end
    end
  end

  assign fir_out   = fir_out_q;
  assign out_valid = out_valid_q;
  assign filled    = (cnt_q == 3'd4);

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_pipeline.sv
`default_nettype none
// tb_fir_tap_pipeline: scoreboard bench for fir_tap_pipeline
module tb_fir_tap_pipeline;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [7:0]  cell_3, cell_2, cell_1, cell_0;
  logic               in_valid, flush, coef_load;
  logic [1:0]         coef_sel;
  logic signed [7:0]  coef_in;
  logic signed [17:0] fir_out;
  logic               out_valid, filled;

  always #5 clock = ~clock;

  fir_tap_pipeline dut (
    .clock(clock), .reset(reset),
    .cell_3(cell_3), .cell_2(cell_2), .cell_1(cell_1), .cell_0(cell_0),
    .in_valid(in_valid), .flush(flush), .coef_load(coef_load),
    .coef_sel(coef_sel), .coef_in(coef_in),
    .fir_out(fir_out), .out_valid(out_valid), .filled(filled)
  );

  typedef struct { int due; int val; } exp_t;
  exp_t sb[$];
  int m_c[4];
  int m_cnt, m_last, cyc, n_out;
  int checks, errors;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_c[k] = 0;
    m_cnt = 0; m_last = 0; sb.delete();
  endtask

  // one clock: update model with the inputs being applied, then check the DUT
  task automatic tick();
    int s;
    if (coef_load) m_c[coef_sel] = int'(coef_in);
    if (flush) begin
      m_cnt = 0; sb.delete();
    end else if (in_valid) begin
      if (m_cnt >= 3) begin
        s = m_c[0]*int'(cell_0) + m_c[1]*int'(cell_1) + m_c[2]*int'(cell_2) + m_c[3]*int'(cell_3);
        sb.push_back('{cyc + 3, s});
      end
      if (m_cnt < 4) m_cnt++;
    end
    @(posedge clock); cyc++; #1;
    checks++;
    if (out_valid) begin
      n_out++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d out_valid=1 required out_valid=0", cyc);
        m_last = int'(fir_out);
      end else begin
        m_last = sb[0].val;
        sb.pop_front();
        if (int'(fir_out) !== m_last) begin
          errors++;
          $display("FAIL sb_value cyc=%0d fir_out=%0d required %0d", cyc, fir_out, m_last);
        end
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      errors++;
      $display("FAIL sb_missing cyc=%0d out_valid=0 required 1 (value %0d)", cyc, sb[0].val);
      sb.pop_front();
    end
    checks++;
    if (!out_valid && int'(fir_out) !== m_last) begin
      errors++;
      $display("FAIL hold cyc=%0d fir_out=%0d required %0d", cyc, fir_out, m_last);
    end
    checks++;
    if (filled !== (m_cnt == 4)) begin
      errors++;
      $display("FAIL filled cyc=%0d filled=%0b required %0b", cyc, filled, (m_cnt == 4));
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; coef_load = 0; coef_sel = 0; coef_in = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic sample(input int a0, input int a1, input int a2, input int a3);
    cell_0 = 8'(a0); cell_1 = 8'(a1); cell_2 = 8'(a2); cell_3 = 8'(a3);
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    int cv[4];
    cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
    for (int k = 0; k < 4; k++) begin
      coef_load = 1; coef_sel = 2'(k); coef_in = 8'(cv[k]);
      tick();
    end
    coef_load = 0;
  endtask

  task automatic test_reset();
    reset = 0; clear_inputs();
    cell_0 = 0; cell_1 = 0; cell_2 = 0; cell_3 = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (fir_out !== 18'sd0) begin errors++; $display("FAIL rst_fir_out got %0d required 0", fir_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b required 0", out_valid); end
    checks++; if (filled !== 1'b0) begin errors++; $display("FAIL rst_filled got %0b required 0", filled); end
    reset = 1;
    idle(2);
    sample(5, 6, 7, 8); sample(-3, 9, 100, -50); sample(1, 1, 1, 1); sample(77, -77, 12, 13);
    idle(3);
    checks++; if (fir_out !== 18'sd0) begin errors++; $display("FAIL rst_coef_zero got %0d required 0", fir_out); end
  endtask

  task automatic test_fill();
    flush = 1; tick(); flush = 0;
    load_coefs(1, 2, 3, 4);
    sample(1, 2, 3, 4); sample(5, 6, 7, 8); sample(9, 9, 9, 9);
    checks++; if (filled !== 1'b0) begin errors++; $display("FAIL fill_before got %0b required 0", filled); end
    sample(40, 30, 20, 10);
    checks++; if (filled !== 1'b1) begin errors++; $display("FAIL fill_after got %0b required 1", filled); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_early got %0b required 0", out_valid); end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || fir_out !== 18'sd200) begin
      errors++; $display("FAIL fill_result out_valid=%0b fir_out=%0d required 1/200", out_valid, fir_out);
    end
    idle(2);
  endtask

  task automatic test_extreme();
    load_coefs(-128, -128, -128, -128);
    sample(-128, -128, -128, -128);
    idle(2);
    checks++; if (fir_out !== 18'sd65536) begin errors++; $display("FAIL ext_pos got %0d required 65536", fir_out); end
    sample(127, 127, 127, 127);
    idle(2);
    checks++; if (fir_out !== -18'sd65024) begin errors++; $display("FAIL ext_neg got %0d required -65024", fir_out); end
    idle(1);
  endtask

  task automatic test_streaming();
    int n0;
    load_coefs(3, -7, 11, -2);
    n0 = n_out;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cell_0 = 8'($urandom); cell_1 = 8'($urandom); cell_2 = 8'($urandom); cell_3 = 8'($urandom);
      tick();
    end
    idle(3);
    checks++;
    if (n_out - n0 != 10) begin errors++; $display("FAIL stream_count got %0d required 10", n_out - n0); end
  endtask

  task automatic test_coef_timing();
    load_coefs(1, 0, 0, 0);
    idle(2);
    sample(10, 0, 0, 0);
    coef_load = 1; coef_sel = 2'd0; coef_in = 8'sd5;
    sample(10, 0, 0, 0);
    coef_load = 0;
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || fir_out !== 18'sd10) begin
      errors++; $display("FAIL coef_old out_valid=%0b fir_out=%0d required 1/10", out_valid, fir_out);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || fir_out !== 18'sd50) begin
      errors++; $display("FAIL coef_new out_valid=%0b fir_out=%0d required 1/50", out_valid, fir_out);
    end
    idle(2);
  endtask

  task automatic test_flush();
    int n0;
    load_coefs(1, 1, 1, 1);
    sample(1, 2, 3, 4); sample(5, 5, 5, 5);
    n0 = n_out;
    flush = 1; cell_0 = 9; in_valid = 1; tick(); flush = 0; in_valid = 0;
    checks++; if (filled !== 1'b0) begin errors++; $display("FAIL flush_filled got %0b required 0", filled); end
    idle(3);
    sample(1, 1, 1, 1); sample(2, 2, 2, 2); sample(3, 3, 3, 3);
    idle(3);
    checks++; if (n_out != n0) begin errors++; $display("FAIL flush_suppress outputs=%0d required 0", n_out - n0); end
    sample(4, 4, 4, 4);
    idle(3);
    checks++; if (fir_out !== 18'sd16) begin errors++; $display("FAIL flush_refill got %0d required 16", fir_out); end
  endtask

  task automatic test_reset_mid();
    sample(20, 20, 20, 20); sample(30, 30, 30, 30);
    #2 reset = 0;
    #1;
    checks++; if (fir_out !== 18'sd0) begin errors++; $display("FAIL arst_fir_out got %0d required 0", fir_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %0b required 0", out_valid); end
    checks++; if (filled !== 1'b0) begin errors++; $display("FAIL arst_filled got %0b required 0", filled); end
    model_reset();
    #1 reset = 1;
    idle(3);
    load_coefs(2, 2, 2, 2);
    sample(1, 1, 1, 1); sample(1, 1, 1, 1); sample(1, 1, 1, 1); sample(1, 1, 1, 1);
    idle(3);
    checks++; if (fir_out !== 18'sd8) begin errors++; $display("FAIL arst_refill got %0d required 8", fir_out); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; n_out = 0;
    test_reset();
    test_fill();
    test_extreme();
    test_streaming();
    test_coef_timing();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
